fs_bh_1bit: RTL and testbench
=============================

Name: fs_bh_1bit

Overview:
- 1-bit full subtractor with two output paths.
- The combinational path computes difference and borrow-out from a_in, b_in and borrow_in with zero latency.
- A registered path on clk latches the result.
- In serial mode the registered path feeds its own borrow back, so multi-bit operands can be subtracted LSB-first, one bit per cycle.
- Leaf arithmetic cell for subtractor chains and bit-serial datapaths.

Parameters:
- RESET_BORROW, default 0: value loaded into borrow_q on reset and on clr (0 or 1).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_in  input  1  minuend bit.
- b_in  input  1  subtrahend bit.
- borrow_in  input  1  external borrow-in, used by the combinational path and by the registered path when serial_mode=0.
- serial_mode  input  1  1 = registered path uses borrow_q as its borrow-in instead of borrow_in.
- en  input  1  registered-path update enable.
- clr  input  1  synchronous clear of registered state.
- diff_out  output  1  combinational difference.
- borrow_out  output  1  combinational borrow-out.
- diff_q  output  1  registered difference.
- borrow_q  output  1  registered borrow-out.
- valid_q  output  1  registered flag: diff_q/borrow_q hold a result computed since the last reset/clr.

Behaviour:
- Combinational path, independent of clk, rst_n, en, clr and serial_mode:
  - diff_out = a_in XOR b_in XOR borrow_in.
  - borrow_out = (~a_in & b_in) | (~a_in & borrow_in) | (b_in & borrow_in).
  - Equivalently, {borrow_out, diff_out} is the 2-bit two's-complement result of a_in - b_in - borrow_in, with borrow_out = 1 when the result is negative.
  - Outputs settle in the same delta as input changes; no X on any fully-defined input.
- Effective registered borrow-in: bsel = serial_mode ? borrow_q : borrow_in.
- Asynchronous reset (rst_n=0), effective immediately regardless of clk:
  - diff_q = 0, borrow_q = RESET_BORROW, valid_q = 0.
- On each clk rising edge with rst_n=1, in priority order:
  1. clr=1: diff_q = 0, borrow_q = RESET_BORROW, valid_q = 0. Overrides en.
  2. else en=1: diff_q = a_in^b_in^bsel; borrow_q = the borrow function of (a_in, b_in, bsel); valid_q = 1.
  3. else: all registers hold.
- Latency: registered outputs reflect inputs one cycle after the sampling edge.
- Serial mode chaining:
  - Each enabled cycle consumes the previous cycle's borrow_q.
  - Assert clr (or reset) before the LSB to start a new word with borrow = RESET_BORROW.
  - Changing serial_mode takes effect on the next enabled edge.
- Reset deassertion: no constraints beyond standard recovery; the first edge after release follows the normal rules.
- Combinational outputs stay valid during reset.

Test Plan:
- Combinational stepping, no clock, 10-unit steps:
  - (a,b,bin) = 000 -> diff 0, borrow 0.
  - 100 -> diff 1, borrow 0.
  - 110 -> diff 0, borrow 0.
  - 101 -> diff 0, borrow 0.
- Exhaustive truth table, all 8 input combinations:
  - 010 -> d1 b1.
  - 001 -> d1 b1.
  - 011 -> d0 b1.
  - 111 -> d1 b1.
  - remaining four combinations as in the stepping scenario.
- Registered parallel mode (serial_mode=0, en=1): apply 011, clock one edge -> diff_q=0, borrow_q=1, valid_q=1. Set en=0, change inputs, clock -> all registers hold.
- Serial subtract 5-3, LSB-first:
  - Setup: clr for one cycle, then serial_mode=1, en=1.
  - a bits 1,0,1; b bits 1,1,0.
  - diff_q sequence: 0,1,0 (result = 2).
  - borrow_q sequence: 0,1,0.
- Serial underflow 2-3:
  - a bits 0,1; b bits 1,1.
  - diff_q sequence: 1,1; final borrow_q = 1 (negative).
- Async reset mid-operation: with borrow_q=1, pulse rst_n low between clock edges -> diff_q=0, borrow_q=RESET_BORROW, valid_q=0 immediately. Also clr and en both high on one edge -> clear wins.

Source files
------------

// File: rtl/fs_bh_1bit_if.sv
// Signal bundle for the 1-bit full subtractor: operand/control inputs plus
// combinational and registered results.
interface fs_bh_1bit_if;
  logic a_in;
  logic b_in;
  logic borrow_in;
  logic serial_mode;
  logic en;
  logic clr;
  logic diff_out;
  logic borrow_out;
  logic diff_q;
  logic borrow_q;
  logic valid_q;

  modport master (
    output a_in, b_in, borrow_in, serial_mode, en, clr,
    input  diff_out, borrow_out, diff_q, borrow_q, valid_q
  );

  modport slave (
    input  a_in, b_in, borrow_in, serial_mode, en, clr,
    output diff_out, borrow_out, diff_q, borrow_q, valid_q
  );
endinterface

// File: rtl/fs_bh_1bit.sv
// 1-bit full subtractor with a zero-latency combinational path and a registered
// path that can feed its own borrow back for LSB-first bit-serial subtraction.
module fs_bh_1bit #(
  parameter bit RESET_BORROW = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  fs_bh_1bit_if.slave  bus
);

  function automatic logic diff_fn(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic borrow_fn(input logic a, input logic b, input logic bin);
    return (~a & b) | (~a & bin) | (b & bin);
  endfunction

  logic diff_p1;
  logic borrow_p1;
  logic vld_p1;
  logic bsel_p0;

  assign bus.diff_out   = diff_fn(bus.a_in, bus.b_in, bus.borrow_in);
  assign bus.borrow_out = borrow_fn(bus.a_in, bus.b_in, bus.borrow_in);

  // In serial mode the previous cycle's borrow chains into this bit.
  assign bsel_p0 = bus.serial_mode ? borrow_p1 : bus.borrow_in;

  // p0 -> p1: clear outranks enable; otherwise registers hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_p1   <= 1'b0;
      borrow_p1 <= RESET_BORROW;
      vld_p1    <= 1'b0;
    end else if (bus.clr) begin
      diff_p1   <= 1'b0;
      borrow_p1 <= RESET_BORROW;
      vld_p1    <= 1'b0;
    end else if (bus.en) begin
      diff_p1   <= diff_fn(bus.a_in, bus.b_in, bsel_p0);
      borrow_p1 <= borrow_fn(bus.a_in, bus.b_in, bsel_p0);
      vld_p1    <= 1'b1;
    end
  end

  assign bus.diff_q   = diff_p1;
  assign bus.borrow_q = borrow_p1;
  assign bus.valid_q  = vld_p1;

endmodule

// File: tb/tb_fs_bh_1bit.sv
// Scoreboard bench for fs_bh_1bit: an arithmetic reference model pushes expected
// results when stimulus is driven; they are popped and compared after the edge.
module tb_fs_bh_1bit;
  localparam bit RB = 1'b0;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [2:0] sb_q[$];
  logic       m_diff, m_borrow, m_valid;

  fs_bh_1bit_if bus ();

  fs_bh_1bit #(.RESET_BORROW(RB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a - b - bin as a signed integer; borrow means a negative result.
  function automatic logic [1:0] ref_sub(input logic a, input logic b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {(r < 0) ? 1'b1 : 1'b0, r[0]};
  endfunction

  task automatic check_comb(input string tag);
    logic [1:0] e;
    e = ref_sub(bus.a_in, bus.b_in, bus.borrow_in);
    chk({tag, "_diff"},   {7'd0, bus.diff_out},   {7'd0, e[0]});
    chk({tag, "_borrow"}, {7'd0, bus.borrow_out}, {7'd0, e[1]});
  endtask

  // One clocked step: drive at negedge, push expected state, pop after posedge.
  task automatic cyc(input string tag, input logic a, input logic b, input logic bin,
                     input logic sm, input logic e, input logic c);
    logic [1:0] r;
    logic [2:0] exp;
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.borrow_in = bin;
    bus.serial_mode = sm; bus.en = e; bus.clr = c;
    if (c) begin
      m_diff = 1'b0; m_borrow = RB; m_valid = 1'b0;
    end else if (e) begin
      r = ref_sub(a, b, sm ? m_borrow : bin);
      m_diff = r[0]; m_borrow = r[1]; m_valid = 1'b1;
    end
    sb_q.push_back({m_valid, m_borrow, m_diff});
    #1 check_comb({tag, "_c"});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_diff_q"},   {7'd0, bus.diff_q},   {7'd0, exp[0]});
      chk({tag, "_borrow_q"}, {7'd0, bus.borrow_q}, {7'd0, exp[1]});
      chk({tag, "_valid_q"},  {7'd0, bus.valid_q},  {7'd0, exp[2]});
    end
  endtask

  logic [2:0] word;
  logic [2:0] pat[8];

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus.a_in = 0; bus.b_in = 0; bus.borrow_in = 0;
    bus.serial_mode = 0; bus.en = 0; bus.clr = 0;
    m_diff = 1'b0; m_borrow = RB; m_valid = 1'b0;
    #12;
    chk("rst_diff_q",   {7'd0, bus.diff_q},   8'd0);
    chk("rst_borrow_q", {7'd0, bus.borrow_q}, {7'd0, RB});
    chk("rst_valid_q",  {7'd0, bus.valid_q},  8'd0);

    // Combinational stepping while held in reset, in (a,b,bin) order.
    pat = '{3'b000, 3'b100, 3'b110, 3'b101, 3'b010, 3'b001, 3'b011, 3'b111};
    for (int i = 0; i < 8; i++) begin
      {bus.a_in, bus.b_in, bus.borrow_in} = pat[i];
      #10 check_comb($sformatf("tt%0b", pat[i]));
    end
    bus.a_in = 0; bus.b_in = 1; bus.borrow_in = 0;
    #1 chk("tt010_const", {6'd0, bus.borrow_out, bus.diff_out}, 8'h3);
    bus.a_in = 1; bus.b_in = 1; bus.borrow_in = 0;
    #1 chk("tt110_const", {6'd0, bus.borrow_out, bus.diff_out}, 8'h0);

    @(negedge clk) rst_n = 1'b1;

    // Parallel mode, then hold with en=0.
    cyc("par", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_const", {5'd0, bus.valid_q, bus.borrow_q, bus.diff_q}, 8'b110);
    cyc("hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Serial 5 - 3 = 2, LSB first.
    cyc("clr1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("s53_0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); word[0] = bus.diff_q;
    cyc("s53_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); word[1] = bus.diff_q;
    cyc("s53_2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); word[2] = bus.diff_q;
    chk("s53_word",   {5'd0, word}, 8'd2);
    chk("s53_borrow", {7'd0, bus.borrow_q}, 8'd0);

    // Serial 2 - 3 underflows.
    cyc("clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("s23_0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); word[0] = bus.diff_q;
    cyc("s23_1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); word[1] = bus.diff_q;
    chk("s23_word",   {6'd0, word[1:0]}, 8'h3);
    chk("s23_borrow", {7'd0, bus.borrow_q}, 8'd1);

    // Async reset pulse between edges while borrow_q=1.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_diff_q",   {7'd0, bus.diff_q},   8'd0);
    chk("arst_borrow_q", {7'd0, bus.borrow_q}, {7'd0, RB});
    chk("arst_valid_q",  {7'd0, bus.valid_q},  8'd0);
    rst_n = 1'b1;
    m_diff = 1'b0; m_borrow = RB; m_valid = 1'b0;

    // clr beats en on the same edge.
    cyc("pre_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("clr_en",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_en_const", {5'd0, bus.valid_q, bus.borrow_q, bus.diff_q}, {6'd0, RB, 1'b0});

    for (int i = 0; i < 40; i++) begin
      cyc("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
